// File: rtl/pll_reset_seq.sv
// Core reset sequencer behind the system PLL: qualifies lock, holds the core in reset,
// then releases it and produces phase-locked 6 MHz / 3 MHz clock enables.
module pll_reset_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CYC  = 1024,
   parameter int HOLD_CYC    = 64,
   parameter int CEN_DIV     = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   input  logic soft_rst,
   output logic core_rst,
   output logic core_rst_n,
   output logic ready,
   output logic cen_6,
   output logic cen_3
);

   localparam int MAX_CYC = (STABLE_CYC > HOLD_CYC) ? STABLE_CYC : HOLD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int CEN_W   = $clog2(CEN_DIV);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CEN_W-1:0] CEN_LAST    = CEN_W'(CEN_DIV - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_p;
   logic                   lock_s;
   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [CEN_W-1:0]       cen_cnt;
   logic                   cen_tog;
   logic                   run_nxt;
   logic                   run_stay;
   logic                   cen_wrap;

   assign lock_s = sync_p[SYNC_STAGES-1];

   // pll_locked is asynchronous to clk; only the last stage feeds the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p <= '0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], pll_locked};
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         WAIT_LOCK: begin
            cnt_nxt = '0;
            if (lock_s) state_nxt = STABLE;
         end
         STABLE: begin
            if (!lock_s)                 state_nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_nxt = HOLD;
            else                         cnt_nxt   = cnt + CNT_W'(1);
         end
         HOLD: begin
            if (!lock_s)               state_nxt = WAIT_LOCK;
            else if (soft_rst)         cnt_nxt   = '0;
            else if (cnt == HOLD_LAST) state_nxt = RUN;
            else                       cnt_nxt   = cnt + CNT_W'(1);
         end
         RUN: begin
            if (!lock_s)       state_nxt = WAIT_LOCK;
            else if (soft_rst) state_nxt = HOLD;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
      // every transition starts the next phase from a zero count
      if (state_nxt != state) cnt_nxt = '0;
   end

   assign run_nxt  = (state_nxt == RUN);
   assign run_stay = (state == RUN) && run_nxt;
   assign cen_wrap = run_stay && (cen_cnt == CEN_LAST);

   // Outputs are decoded from the next state so core_rst moves on the same edge as the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT_LOCK;
         cnt        <= '0;
         cen_cnt    <= '0;
         cen_tog    <= 1'b0;
         core_rst   <= 1'b1;
         core_rst_n <= 1'b0;
         ready      <= 1'b0;
         cen_6      <= 1'b0;
         cen_3      <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         core_rst   <= !run_nxt;
         core_rst_n <= run_nxt;
         ready      <= run_nxt;
         cen_6      <= cen_wrap;
         cen_3      <= cen_wrap && cen_tog;
         if (!run_nxt) begin
            cen_cnt <= '0;
            cen_tog <= 1'b0;
         end else if (run_stay) begin
            cen_cnt <= cen_wrap ? '0 : cen_cnt + CEN_W'(1);
            cen_tog <= cen_tog ^ cen_wrap;
         end
      end
   end

endmodule
